mul_seq_ctrl: RTL and testbench

//  Sequencer for a multi-cycle unsigned shift-add multiplier in the EX stage.
//  - Started by ID/EX when the mul-activate control bit is set.
//  - Holds the front of the pipeline (PC, IF/ID, ID/EX) while iterating.
//  - Releases the pipeline with the full 2*XLEN-bit product.
//  - Aborts cleanly on a pipeline flush.

---
 rtl/mul_seq_ctrl.sv | 176 +++++++++++++++++
 tb/tb_mul_seq_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_seq_ctrl.sv
// -----------------------------------------------------------------------------
// mul_seq_ctrl
//
// Sequencer for a multi-cycle unsigned shift-add multiplier sitting in the EX
// stage. A multiply is accepted from ID/EX when start is raised in IDLE. While
// iterating, the front of the pipeline (PC, IF/ID, ID/EX) is frozen through
// stall. When iteration finishes, the full 2*XLEN-bit product is published on
// result/result_hi and done pulses for one cycle with stall low, so EX/MEM
// captures the product. A flush aborts the operation without a done pulse.
//
// Parameters
//   XLEN       operand width; the product is 2*XLEN bits
//   EARLY_OUT  1: stop once the remaining multiplier bits are all zero
//              0: always run XLEN iterations
//   CNT_W      iteration counter width; 2**CNT_W must exceed XLEN
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   start      multiply request, sampled only in IDLE
//   flush      abort the current operation (branch/jump flush)
//   op_a       multiplicand, sampled with start
//   op_b       multiplier, sampled with start
//   stall      hold PC / IF-ID / ID-EX write enables low
//   busy       high in RUN and DONE
//   done       one-cycle pulse; result/result_hi valid
//   result     product[XLEN-1:0]
//   result_hi  product[2*XLEN-1:XLEN]
// -----------------------------------------------------------------------------
module mul_seq_ctrl #(
  parameter int XLEN      = 32,
  parameter bit EARLY_OUT = 1'b1,
  parameter int CNT_W     = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            flush,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [XLEN-1:0] result_hi
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // Datapath: the multiplicand is pre-widened so that shifting it left never
  // loses bits and the accumulator add cannot overflow.
  logic [2*XLEN-1:0] mcand;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   mplier;
  logic [CNT_W-1:0]  cnt;

  // Per-cycle control strobes decoded by the FSM.
  logic accept;    // load operands, enter RUN
  logic iterate;   // perform one shift-add step
  logic capture;   // publish acc on result/result_hi
  logic run_exit;  // RUN has nothing left to do

  // Exit is checked before iterating: a zero multiplier (early-out) or a full
  // count leaves RUN without touching the datapath in that cycle.
  always_comb begin
    run_exit = (cnt == CNT_W'(XLEN)) || (EARLY_OUT && (mplier == '0));
  end

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next-state and outputs
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block gets a default first, so no path through
  // the case statement leaves a signal unassigned and infers a latch.
  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    iterate   = 1'b0;
    capture   = 1'b0;

    unique case (state)
      IDLE: begin
        // Flush beats start. stall is raised in the request cycle itself so
        // the multiply instruction stays parked in ID/EX. The reset term keeps
        // stall low while reset is held, whatever start does.
        if (start && !flush && reset) begin
          accept    = 1'b1;
          stall     = 1'b1;
          state_nxt = RUN;
        end
      end

      RUN: begin
        busy  = 1'b1;
        stall = 1'b1;
        if (flush) begin
          // Abort: no capture, so result/result_hi keep the previous product.
          state_nxt = IDLE;
        end else if (run_exit) begin
          capture   = 1'b1;
          state_nxt = DONE;
        end else begin
          iterate = 1'b1;
        end
      end

      DONE: begin
        // stall stays low so the pipeline advances and EX/MEM takes the
        // product; start here is ignored because IDLE is the only entry point.
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Shift-add datapath and result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
      result    <= '0;
      result_hi <= '0;
    end else begin
      if (accept) begin
        mcand  <= {{XLEN{1'b0}}, op_a};
        mplier <= op_b;
        acc    <= '0;
        cnt    <= '0;
      end else if (iterate) begin
        if (mplier[0]) begin
          acc <= acc + mcand;
        end
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + CNT_W'(1);
      end

      if (capture) begin
        result    <= acc[XLEN-1:0];
        result_hi <= acc[2*XLEN-1:XLEN];
      end
    end
  end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mul_seq_ctrl
//
// Directed bench for mul_seq_ctrl (XLEN=32, EARLY_OUT=1). Stimulus pushes the
// hand-computed product and the cycle in which done must appear onto a
// scoreboard queue; an independent monitor pops and compares whenever done is
// seen. Cycle-level stall/busy/reset behaviour is checked inline.
// -----------------------------------------------------------------------------
module tb_mul_seq_ctrl;

  localparam int XLEN = 32;

  logic            clk;
  logic            reset;
  logic            start;
  logic            flush;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            stall;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [XLEN-1:0] result_hi;

  mul_seq_ctrl #(
    .XLEN      (XLEN),
    .EARLY_OUT (1'b1),
    .CNT_W     (6)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .flush     (flush),
    .op_a      (op_a),
    .op_b      (op_b),
    .stall     (stall),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .result_hi (result_hi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle number; the value seen during a cycle identifies it.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] prod;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise start with the given operands in the current cycle and record the
  // expected product together with its done cycle (k iterations -> cycle k+2).
  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] prod, input int k);
    exp_t e;
    start  = 1'b1;
    op_a   = a;
    op_b   = b;
    e.prod = prod;
    e.cyc  = cyc + k + 2;
    sb.push_back(e);
  endtask

  task automatic wait_drain(input int max_cycles);
    int n = 0;
    while (sb.size() != 0 && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  // Monitor: compares every done pulse against the scoreboard head.
  always @(negedge clk) begin
    if (reset === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 64'(done), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("product", {result_hi, result}, e.prod);
        check("done_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    start = 1'b0;
    flush = 1'b0;
    op_a  = '0;
    op_b  = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_result_hi", 64'(result_hi), 64'd0);
    reset = 1'b1;

    // T1 + T6: 3*5 with start (9,9) held through RUN and DONE, then 9*9.
    tick();
    issue(32'd3, 32'd5, 64'd15, 3);
    @(negedge clk);
    check("t1_stall_c0", 64'(stall), 64'd1);
    for (int i = 1; i <= 5; i++) begin
      tick();
      start = 1'b1;
      op_a  = 32'd9;
      op_b  = 32'd9;
      @(negedge clk);
      check($sformatf("t1_stall_c%0d", i), 64'(stall), (i <= 4) ? 64'd1 : 64'd0);
      check($sformatf("t1_busy_c%0d", i), 64'(busy), 64'd1);
    end
    tick();
    issue(32'd9, 32'd9, 64'd81, 4);
    @(negedge clk);
    check("t6_stall_c0", 64'(stall), 64'd1);
    tick();
    start = 1'b0;
    wait_drain(20);

    // T3: zero multiplier exits immediately.
    tick();
    issue(32'h1234, 32'd0, 64'd0, 0);
    @(negedge clk);
    check("t3_stall_c0", 64'(stall), 64'd1);
    tick();
    start = 1'b0;
    @(negedge clk);
    check("t3_stall_c1", 64'(stall), 64'd1);
    tick();
    @(negedge clk);
    check("t3_stall_c2", 64'(stall), 64'd0);
    wait_drain(5);

    // T2: full-width operands, 32 iterations.
    tick();
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 32);
    tick();
    start = 1'b0;
    wait_drain(40);

    // T4: flush in cycle 6 of a long multiply; no done, result unchanged.
    tick();
    start = 1'b1;
    op_a  = 32'd7;
    op_b  = 32'h8000_0000;
    tick();
    start = 1'b0;
    repeat (4) tick();
    tick();
    flush = 1'b1;
    @(negedge clk);
    check("t4_busy_c6", 64'(busy), 64'd1);
    tick();
    flush = 1'b0;
    @(negedge clk);
    check("t4_stall_c7", 64'(stall), 64'd0);
    check("t4_busy_c7", 64'(busy), 64'd0);
    check("t4_result", 64'(result), 64'h0000_0001);
    check("t4_result_hi", 64'(result_hi), 64'hFFFF_FFFE);
    repeat (40) tick();

    // flush and start together in IDLE: start is ignored.
    tick();
    start = 1'b1;
    flush = 1'b1;
    op_a  = 32'd2;
    op_b  = 32'd3;
    @(negedge clk);
    check("fs_stall", 64'(stall), 64'd0);
    tick();
    start = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    check("fs_busy", 64'(busy), 64'd0);

    // T5: asynchronous reset in cycle 10 of a full-width multiply.
    tick();
    start = 1'b1;
    op_a  = 32'hFFFF_FFFF;
    op_b  = 32'hFFFF_FFFF;
    tick();
    start = 1'b0;
    repeat (9) tick();
    #2;
    reset = 1'b0;
    #1;
    check("t5_stall", 64'(stall), 64'd0);
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_done", 64'(done), 64'd0);
    check("t5_result", 64'(result), 64'd0);
    check("t5_result_hi", 64'(result_hi), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Recovery after reset: 6*7.
    tick();
    issue(32'd6, 32'd7, 64'd42, 3);
    tick();
    start = 1'b0;
    wait_drain(10);

    repeat (3) tick();
    check("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
